vrf_addr_sequencer: RTL and testbench

VRF_ADDR_SEQUENCER -- requirements
Module: vrf_addr_sequencer

---
 rtl/vrf_addr_sequencer_pkg.sv | 43 ++++
 rtl/vrf_addr_sequencer_if.sv | 44 ++++
 rtl/vrf_addr_gen.sv | 36 +++
 rtl/vrf_addr_sequencer.sv | 112 +++++++++++
 tb/tb_vrf_addr_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vrf_addr_sequencer_pkg.sv
// Shared vector-core definitions for the VRF address sequencer:
//   - LMUL group-size encoding
//   - VRF geometry derivations (memory depth, address width, words per
//     register per lane, word-counter width)
//   - sequencer FSM state encoding
package vrf_addr_sequencer_pkg;

  typedef enum logic [1:0] {
    LMUL_1 = 2'd0,
    LMUL_2 = 2'd1,
    LMUL_4 = 2'd2,
    LMUL_8 = 2'd3
  } lmul_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  function automatic int mem_depth(input int vlen, input int lanes);
    return vlen / lanes;
  endfunction

  function automatic int addr_width(input int vlen, input int lanes);
    return $clog2(vlen / lanes);
  endfunction

  // 32-bit words held by one vector register within one lane
  function automatic int regs_words(input int vlen, input int lanes);
    return vlen / 32 / lanes;
  endfunction

  // Counter must hold the full 8-register group count inclusively
  function automatic int cnt_width(input int vlen, input int lanes);
    return $clog2(8 * regs_words(vlen, lanes)) + 1;
  endfunction

  function automatic int lmul_regs(input lmul_e l);
    return 32'd1 << l;
  endfunction

endpackage

// File: rtl/vrf_addr_sequencer_if.sv
// Handshake/bus bundle between an instruction issuer / datapath (master)
// and the VRF address sequencer (slave).
//   start_vld_i/start_rdy_o   : instruction request / sequencer idle
//   lmul_i, num_words_i        : group size encoding, words per lane
//   starting_*_i               : 8 packed per-register base addresses
//   rd_vld_o/rd_rdy_i          : read address handshake
//   raddr0_o, raddr1_o         : read addresses for both source operands
//   wr_en_i, waddr_o           : returning result word and its address
//   done_o                     : instruction complete pulse
interface vrf_addr_sequencer_if #(
  parameter int AW = 9,
  parameter int CW = 8
) ();

  logic            start_vld_i;
  logic            start_rdy_o;
  logic [1:0]      lmul_i;
  logic [CW-1:0]   num_words_i;
  logic [8*AW-1:0] starting_raddr0_i;
  logic [8*AW-1:0] starting_raddr1_i;
  logic [8*AW-1:0] starting_waddr_i;
  logic            rd_vld_o;
  logic            rd_rdy_i;
  logic [AW-1:0]   raddr0_o;
  logic [AW-1:0]   raddr1_o;
  logic            wr_en_i;
  logic [AW-1:0]   waddr_o;
  logic            done_o;

  modport master (
    output start_vld_i, lmul_i, num_words_i,
           starting_raddr0_i, starting_raddr1_i, starting_waddr_i,
           rd_rdy_i, wr_en_i,
    input  start_rdy_o, rd_vld_o, raddr0_o, raddr1_o, waddr_o, done_o
  );

  modport slave (
    input  start_vld_i, lmul_i, num_words_i,
           starting_raddr0_i, starting_raddr1_i, starting_waddr_i,
           rd_rdy_i, wr_en_i,
    output start_rdy_o, rd_vld_o, raddr0_o, raddr1_o, waddr_o, done_o
  );

endinterface

// File: rtl/vrf_addr_gen.sv
// Combinational VRF address generator: splits a word index into a register
// within the group (idx / RS) and an offset inside that register
// (idx % RS), then adds the offset to that register's base, modulo 2^AW.
//   bases : 8 packed per-register base addresses, segment g at [g*AW +: AW]
//   idx   : word index within the instruction
//   addr  : resulting VRF address
module vrf_addr_gen #(
  parameter int AW = 9,
  parameter int CW = 8,
  parameter int RS = 16
) (
  input  logic [8*AW-1:0] bases,
  input  logic [CW-1:0]   idx,
  output logic [AW-1:0]   addr
);

  localparam logic [CW-1:0] RS_W = CW'(RS);

  logic [AW-1:0] seg_base [8];
  logic [CW-1:0] seg;
  logic [CW-1:0] off;
  logic [2:0]    sel;

  always_comb begin
    for (int unsigned g = 0; g < 8; g++) begin
      seg_base[g] = bases[g*AW +: AW];
    end
    seg  = idx / RS_W;
    off  = idx % RS_W;
    // A finished counter sits at n, which may point one register past the
    // group; clamp so the select never leaves the table.
    sel  = (seg > CW'(7)) ? 3'd7 : seg[2:0];
    addr = seg_base[sel] + AW'(off);
  end

endmodule

// File: rtl/vrf_addr_sequencer.sv
// VRF address sequencer: accepts an instruction (bases, LMUL, word count),
// streams read addresses under a valid/ready handshake, tracks returning
// result words to supply their write addresses, and pulses done when the
// last write has landed.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : vrf_addr_sequencer_if slave modport (see interface file)
module vrf_addr_sequencer
  import vrf_addr_sequencer_pkg::*;
#(
  parameter int VLEN      = 4096,
  parameter int VLANE_NUM = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  vrf_addr_sequencer_if.slave   bus
);

  localparam int AW = addr_width(VLEN, VLANE_NUM);
  localparam int RS = regs_words(VLEN, VLANE_NUM);
  localparam int CW = cnt_width(VLEN, VLANE_NUM);

  seq_state_e      state;
  seq_state_e      state_nxt;
  logic [CW-1:0]   rc;
  logic [CW-1:0]   wc;
  logic [CW-1:0]   n_words;
  logic [CW-1:0]   n_req;
  logic [CW-1:0]   cap;
  logic [8*AW-1:0] r0_base;
  logic [8*AW-1:0] r1_base;
  logic [8*AW-1:0] w_base;
  logic            done;
  logic            accept;
  logic            rd_fire;
  logic            wr_fire;
  logic            last_wr;

  always_comb begin
    cap   = CW'(lmul_regs(lmul_e'(bus.lmul_i)) * RS);
    n_req = (bus.num_words_i < cap) ? bus.num_words_i : cap;
  end

  assign accept  = (state == ST_IDLE) && bus.start_vld_i;
  assign rd_fire = (state == ST_RUN) && bus.rd_rdy_i;
  assign wr_fire = (state != ST_IDLE) && bus.wr_en_i && (wc != n_words);
  assign last_wr = wr_fire && (wc == n_words - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && (n_req != '0)) state_nxt = ST_RUN;
      ST_RUN: begin
        if (rd_fire && (rc == n_words - 1'b1)) state_nxt = ST_DRAIN;
        // Final write wins over the read-done transition when both land
        // together, so the instruction never stalls in DRAIN.
        if (last_wr) state_nxt = ST_IDLE;
      end
      ST_DRAIN: if (last_wr) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      rc      <= '0;
      wc      <= '0;
      n_words <= '0;
      r0_base <= '0;
      r1_base <= '0;
      w_base  <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (accept && (n_req == '0)) || last_wr;
      if (accept) begin
        r0_base <= bus.starting_raddr0_i;
        r1_base <= bus.starting_raddr1_i;
        w_base  <= bus.starting_waddr_i;
        n_words <= n_req;
        rc      <= '0;
        wc      <= '0;
      end else begin
        if (rd_fire) rc <= rc + 1'b1;
        if (wr_fire) wc <= wc + 1'b1;
      end
    end
  end

  assign bus.start_rdy_o = (state == ST_IDLE);
  assign bus.rd_vld_o    = (state == ST_RUN);
  assign bus.done_o      = done;

  vrf_addr_gen #(.AW(AW), .CW(CW), .RS(RS)) u_raddr0 (
    .bases (r0_base),
    .idx   (rc),
    .addr  (bus.raddr0_o)
  );

  vrf_addr_gen #(.AW(AW), .CW(CW), .RS(RS)) u_raddr1 (
    .bases (r1_base),
    .idx   (rc),
    .addr  (bus.raddr1_o)
  );

  vrf_addr_gen #(.AW(AW), .CW(CW), .RS(RS)) u_waddr (
    .bases (w_base),
    .idx   (wc),
    .addr  (bus.waddr_o)
  );

endmodule

// File: tb/tb_vrf_addr_sequencer.sv
// Self-checking bench for vrf_addr_sequencer: directed scenarios plus
// randomized instructions, checked against a transaction-level model that
// tracks only "busy", word count n, reads issued and writes returned.
module tb_vrf_addr_sequencer;

  localparam int VLEN  = 4096;
  localparam int LANES = 8;
  localparam int DEPTH = VLEN / LANES;
  localparam int AW    = $clog2(DEPTH);
  localparam int RS    = VLEN / 32 / LANES;
  localparam int CW    = $clog2(8 * RS) + 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  vrf_addr_sequencer_if #(.AW(AW), .CW(CW)) bus ();

  vrf_addr_sequencer #(.VLEN(VLEN), .VLANE_NUM(LANES)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // stimulus base tables
  int s_r0 [8];
  int s_r1 [8];
  int s_w  [8];

  // reference model state
  bit m_busy = 0;
  bit m_done = 0;
  int m_n = 0;
  int m_reads = 0;
  int m_writes = 0;
  int m_r0 [8];
  int m_r1 [8];
  int m_w  [8];
  int hs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_addr(input int sel, input int w);
    int b;
    b = (sel == 0) ? m_r0[w / RS] : (sel == 1) ? m_r1[w / RS] : m_w[w / RS];
    return (b + w % RS) % DEPTH;
  endfunction

  task automatic check_outputs();
    check("start_rdy", bus.start_rdy_o, !m_busy);
    check("rd_vld", bus.rd_vld_o, m_busy && (m_reads < m_n));
    check("done", bus.done_o, m_done);
    if (m_busy && (m_reads < m_n)) begin
      check("raddr0", bus.raddr0_o, ref_addr(0, m_reads));
      check("raddr1", bus.raddr1_o, ref_addr(1, m_reads));
    end
    if (m_busy) check("waddr", bus.waddr_o, ref_addr(2, m_writes));
  endtask

  task automatic model_update(input bit sv, input int lmul, input int nw,
                              input bit rdy, input bit wen);
    bit rd;
    int cap;
    rd = m_busy && (m_reads < m_n) && rdy;
    m_done = 0;
    if (!m_busy) begin
      if (sv) begin
        cap = RS << lmul;
        m_n = (nw < cap) ? nw : cap;
        for (int g = 0; g < 8; g++) begin
          m_r0[g] = s_r0[g];
          m_r1[g] = s_r1[g];
          m_w[g]  = s_w[g];
        end
        m_reads = 0;
        m_writes = 0;
        if (m_n == 0) m_done = 1;
        else m_busy = 1;
      end
    end else begin
      if (rd) m_reads++;
      if (wen && (m_writes < m_n)) begin
        m_writes++;
        if (m_writes == m_n) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit sv, input int lmul, input int nw,
                       input bit rdy, input bit wen);
    bus.start_vld_i = sv;
    bus.lmul_i      = 2'(lmul);
    bus.num_words_i = CW'(nw);
    bus.rd_rdy_i    = rdy;
    bus.wr_en_i     = wen;
    for (int g = 0; g < 8; g++) begin
      bus.starting_raddr0_i[g*AW +: AW] = AW'(s_r0[g]);
      bus.starting_raddr1_i[g*AW +: AW] = AW'(s_r1[g]);
      bus.starting_waddr_i[g*AW +: AW]  = AW'(s_w[g]);
    end
  endtask

  // One clock: check at the falling edge, drive, let the rising edge act.
  task automatic step(input bit sv, input int lmul, input int nw,
                      input bit rdy, input bit wen);
    @(negedge clk);
    check_outputs();
    drive(sv, lmul, nw, rdy, wen);
    if (bus.rd_vld_o && rdy) hs_cnt++;
    @(posedge clk);
    model_update(sv, lmul, nw, rdy, wen);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_vld", bus.rd_vld_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_raddr0", bus.raddr0_o, 0);
    check("rst_raddr1", bus.raddr1_o, 0);
    check("rst_waddr", bus.waddr_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    check_reset_outputs();
    m_busy = 0;
    m_done = 0;
    m_n = 0;
    m_reads = 0;
    m_writes = 0;
    for (int g = 0; g < 8; g++) begin
      m_r0[g] = 0;
      m_r1[g] = 0;
      m_w[g]  = 0;
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // mode: 0 = rd_rdy always 1, 1 = toggle 1/0, 2 = random
  task automatic run_instr(input int lmul, input int nw, input int mode, input int abort_at);
    int cycles;
    bit rdy;
    bit rd;
    bit wen;
    int exp_n;
    exp_n = (nw < (RS << lmul)) ? nw : (RS << lmul);
    hs_cnt = 0;
    step(1, lmul, nw, 1, 1'($urandom % 2));
    cycles = 0;
    while (m_busy && cycles < 600) begin
      if (abort_at >= 0 && m_reads == abort_at) begin
        do_reset();
        repeat (3) step(0, 0, 0, 1, 1);
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cycles % 2) == 0) : (($urandom % 3) != 0);
      rd  = (m_reads < m_n) && rdy;
      wen = m_writes < (m_reads + int'(rd));
      if (mode == 2) wen = wen && (($urandom % 4) != 0);
      step(1'($urandom % 2), $urandom % 4, $urandom, rdy, wen);
      cycles++;
    end
    if (m_busy) check("instr_timeout", 1, 0);
    step(0, 0, 0, 0, 1'($urandom % 2));
    check("handshakes", hs_cnt, exp_n);
  endtask

  task automatic set_bases(input int r0, input int r1, input int w);
    for (int g = 0; g < 8; g++) begin
      s_r0[g] = (r0 + 16 * g) % DEPTH;
      s_r1[g] = (r1 + 16 * g) % DEPTH;
      s_w[g]  = (w + 16 * g) % DEPTH;
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_bases(0, 0, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 0, 0, 0);

    // lmul=1, n=20, always ready: reads 32..47 then 48..51
    set_bases(32, 200, 300);
    run_instr(1, 20, 0, -1);
    // same with ready toggling
    run_instr(1, 20, 1, -1);
    // lmul=0 clamps 40 words to 16
    run_instr(0, 40, 0, -1);
    run_instr(0, 40, 2, -1);
    // zero words: done one cycle after accept, no reads
    run_instr(2, 0, 0, -1);
    // single word with write landing on the read handshake
    set_bases(100, 400, 500);
    run_instr(3, 1, 0, -1);
    // full LMUL=8 group with base wrap-around
    set_bases(480, 10, 505);
    run_instr(3, 128, 2, -1);
    // reset in the middle of RUN, then a normal instruction
    set_bases(32, 200, 300);
    run_instr(1, 20, 0, 5);
    run_instr(1, 20, 0, -1);

    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < 8; g++) begin
        s_r0[g] = $urandom % DEPTH;
        s_r1[g] = $urandom % DEPTH;
        s_w[g]  = $urandom % DEPTH;
      end
      run_instr($urandom % 4, ($urandom % 4 == 0) ? ($urandom % 256) : $urandom_range(0, 8 * RS),
                2, ((i % 13) == 7) ? int'($urandom % 4) : -1);
      repeat ($urandom % 3) step(0, 0, 0, 1'($urandom % 2), 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
